// File: rtl/mem_axi_lsu_pkg.sv
// Shared LSU definitions: RV32 funct3 codes, AXI response codes, FSM states.
// Misaligned-access classification is used when LSU_MISALIGN_CHECK_EN is defined.
package mem_axi_lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } lsu_state_e;

  // Unsupported funct3 codes count as word accesses.
  function automatic logic misaligned(input logic [2:0] f3, input logic we,
                                      input logic [1:0] lane);
    logic is_byte;
    logic is_half;
    if (we) begin
      is_byte = (f3 == FUNCT3_SB);
      is_half = (f3 == FUNCT3_SH);
    end else begin
      is_byte = (f3 == FUNCT3_LB) || (f3 == FUNCT3_LBU);
      is_half = (f3 == FUNCT3_LH) || (f3 == FUNCT3_LHU);
    end
    if (is_byte)      return 1'b0;
    else if (is_half) return lane[0];
    else              return (lane != 2'b00);
  endfunction

endpackage

// File: rtl/mem_axi_lsu_lane_align.sv
// Combinational byte-lane logic: load extraction/extension from a read word,
// and store data replication plus write strobe generation.
module mem_axi_lsu_lane_align
  import mem_axi_lsu_pkg::*;
(
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_lane,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   ld_data,
  input  logic [2:0]        st_funct3,
  input  logic [1:0]        st_lane,
  input  logic [XLEN-1:0]   st_wdata,
  output logic [XLEN-1:0]   wdata,
  output logic [STRB_W-1:0] wstrb
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rdata[{ld_lane, 3'b000} +: 8];
    rhalf = rdata[{ld_lane[1], 4'b0000} +: 16];
    unique case (ld_funct3)
      FUNCT3_LB:  ld_data = {{24{rbyte[7]}}, rbyte};
      FUNCT3_LBU: ld_data = {24'd0, rbyte};
      FUNCT3_LH:  ld_data = {{16{rhalf[15]}}, rhalf};
      FUNCT3_LHU: ld_data = {16'd0, rhalf};
      FUNCT3_LW:  ld_data = rdata;
      default:    ld_data = rdata;
    endcase
  end

  // Narrow stores replicate across the word so the strobe alone picks the lane.
  always_comb begin
    unique case (st_funct3)
      FUNCT3_SB: begin
        wdata = {4{st_wdata[7:0]}};
        wstrb = 4'b0001 << st_lane;
      end
      FUNCT3_SH: begin
        wdata = {2{st_wdata[15:0]}};
        wstrb = 4'b0011 << {st_lane[1], 1'b0};
      end
      FUNCT3_SW: begin
        wdata = st_wdata;
        wstrb = 4'hF;
      end
      default: begin
        wdata = st_wdata;
        wstrb = 4'hF;
      end
    endcase
  end

endmodule

// File: rtl/mem_axi_lsu.sv
// Memory-stage load/store unit running one AXI4-Lite transaction at a time.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned H/W accesses without bus traffic.
module mem_axi_lsu
  import mem_axi_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] load_data,
  output logic              store_done,
  output logic              bus_err,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready
);

  lsu_state_e  state;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
  logic        aw_done;
  logic        w_done;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_data;
  logic [3:0]        st_strb;

  logic aw_hs, w_hs, aw_done_n, w_done_n, rd_fire, wr_fire, accept;

  mem_axi_lsu_lane_align u_lane_align (
    .ld_funct3 (funct3_q),
    .ld_lane   (lane_q),
    .rdata     (m_rdata),
    .ld_data   (ld_data),
    .st_funct3 (req_funct3),
    .st_lane   (req_addr[1:0]),
    .st_wdata  (req_wdata),
    .wdata     (st_data),
    .wstrb     (st_strb)
  );

  assign aw_hs     = m_awvalid & m_awready;
  assign w_hs      = m_wvalid & m_wready;
  assign aw_done_n = aw_done | aw_hs;
  assign w_done_n  = w_done | w_hs;
  assign rd_fire   = (state == RD_DATA) & m_rvalid;
  assign wr_fire   = (state == WR_RESP) & m_bvalid;
  assign accept    = req_valid & req_ready;

`ifdef LSU_MISALIGN_CHECK_EN
  logic mis_pend;
  logic mis_we;
  logic mis_req;

  assign mis_req      = misaligned(req_funct3, req_we, req_addr[1:0]);
  // The trap pulse cycle blocks acceptance so responses never overlap a new request.
  assign req_ready    = (state == IDLE) & ~mis_pend;
  assign misalign_err = ~rst & mis_pend;
  assign lsu_rvalid   = ~rst & (rd_fire | (mis_pend & ~mis_we));
  assign store_done   = ~rst & (wr_fire | (mis_pend & mis_we));
`else
  assign req_ready    = (state == IDLE);
  assign misalign_err = 1'b0;
  assign lsu_rvalid   = ~rst & rd_fire;
  assign store_done   = ~rst & wr_fire;
`endif

  assign load_data = rd_fire ? ld_data : '0;
  assign bus_err   = ~rst & ((rd_fire & (m_rresp != AXI_RESP_OKAY)) |
                             (wr_fire & (m_bresp != AXI_RESP_OKAY)));

  // Transaction FSM; all AXI valids/readies and payloads are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lane_q    <= '0;
      funct3_q  <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      m_araddr  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      m_awaddr  <= '0;
      m_awvalid <= 1'b0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      mis_pend  <= 1'b0;
      mis_we    <= 1'b0;
`endif
    end else begin
`ifdef LSU_MISALIGN_CHECK_EN
      mis_pend <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (accept) begin
            lane_q   <= req_addr[1:0];
            funct3_q <= req_funct3;
`ifdef LSU_MISALIGN_CHECK_EN
            if (mis_req) begin
              mis_pend <= 1'b1;
              mis_we   <= req_we;
            end else
`endif
            if (req_we) begin
              m_awaddr  <= {req_addr[ADDR_W-1:2], 2'b00};
              m_wdata   <= st_data;
              m_wstrb   <= st_strb;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              state     <= WR_REQ;
            end else begin
              m_araddr  <= {req_addr[ADDR_W-1:2], 2'b00};
              m_arvalid <= 1'b1;
              state     <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_rvalid) begin
            m_rready <= 1'b0;
            state    <= IDLE;
          end
        end
        WR_REQ: begin
          if (aw_hs) m_awvalid <= 1'b0;
          if (w_hs)  m_wvalid  <= 1'b0;
          if (aw_done_n && w_done_n) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            m_bready <= 1'b1;
            state    <= WR_RESP;
          end else begin
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
          end
        end
        WR_RESP: begin
          if (m_bvalid) begin
            m_bready <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_axi_lsu.sv
// Directed bench for mem_axi_lsu; the slave side is driven cycle by cycle.
// Misaligned-trap checks follow LSU_MISALIGN_CHECK_EN.
module tb_mem_axi_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        lsu_rvalid, store_done, bus_err, misalign_err;
  logic [31:0] load_data;
  logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [1:0]  m_rresp, m_bresp;
  logic [3:0]  m_wstrb;
  logic        m_bvalid, m_bready;

  int vectors = 0;
  int miscompares = 0;

  mem_axi_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .lsu_rvalid(lsu_rvalid), .load_data(load_data), .store_done(store_done),
    .bus_err(bus_err), .misalign_err(misalign_err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rdata, input logic [1:0] rresp,
                          input logic [31:0] exp_araddr, input logic [31:0] exp_data,
                          input logic exp_err);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3; req_addr = addr;
    m_arready = 1'b1;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk({tag, ".arvalid"}, 32'(m_arvalid), 32'd1);
    chk({tag, ".araddr"}, m_araddr, exp_araddr);
    chk({tag, ".early_rvalid"}, 32'(lsu_rvalid), 32'd0);
    tick();
    m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = rdata; m_rresp = rresp;
    #1;
    chk({tag, ".lsu_rvalid"}, 32'(lsu_rvalid), 32'd1);
    chk({tag, ".load_data"}, load_data, exp_data);
    chk({tag, ".bus_err"}, 32'(bus_err), 32'(exp_err));
    chk({tag, ".misalign_err"}, 32'(misalign_err), 32'd0);
    tick();
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    #1;
    chk({tag, ".ready_after"}, 32'(req_ready), 32'd1);
    chk({tag, ".rvalid_after"}, 32'(lsu_rvalid), 32'd0);
  endtask

  task automatic run_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] wd, input logic [1:0] bresp,
                           input logic [31:0] exp_awaddr, input logic [31:0] exp_wdata,
                           input logic [3:0] exp_strb, input logic exp_err);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    m_awready = 1'b1; m_wready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk({tag, ".aw_w_valid"}, 32'({m_awvalid, m_wvalid}), 32'd3);
    chk({tag, ".awaddr"}, m_awaddr, exp_awaddr);
    chk({tag, ".wdata"}, m_wdata, exp_wdata);
    chk({tag, ".wstrb"}, 32'(m_wstrb), 32'(exp_strb));
    tick();
    m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid = 1'b1; m_bresp = bresp;
    #1;
    chk({tag, ".bready"}, 32'(m_bready), 32'd1);
    chk({tag, ".store_done"}, 32'(store_done), 32'd1);
    chk({tag, ".bus_err"}, 32'(bus_err), 32'(exp_err));
    tick();
    m_bvalid = 1'b0; m_bresp = 2'b00;
    #1;
    chk({tag, ".done_after"}, 32'(store_done), 32'd0);
    chk({tag, ".ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    m_arready = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rvalid = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst.valids", 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
                          lsu_rvalid, store_done, bus_err, misalign_err}), 32'd0);
    chk("rst.araddr", m_araddr, 32'd0);
    chk("rst.awaddr", m_awaddr, 32'd0);
    chk("rst.wdata", m_wdata, 32'd0);
    chk("rst.wstrb", 32'(m_wstrb), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst.req_ready", 32'(req_ready), 32'd1);

    // Word, byte and half loads at minimum latency
    run_load("lw100", 32'h100, 3'b010, 32'hDEADBEEF, 2'b00, 32'h100, 32'hDEADBEEF, 1'b0);
    run_load("lb103", 32'h103, 3'b000, 32'h80FF0000, 2'b00, 32'h100, 32'hFFFFFF80, 1'b0);
    run_load("lbu103", 32'h103, 3'b100, 32'h80FF0000, 2'b00, 32'h100, 32'h00000080, 1'b0);
    run_load("lhu002", 32'h002, 3'b101, 32'h9ABC5678, 2'b00, 32'h000, 32'h00009ABC, 1'b0);
    run_load("lb001", 32'h001, 3'b000, 32'h0000_7F00, 2'b00, 32'h000, 32'h0000007F, 1'b0);
    run_load("f3_111", 32'h40, 3'b111, 32'h13579BDF, 2'b00, 32'h040, 32'h13579BDF, 1'b0);

    // SB with AW late by three cycles, W immediate
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h102; req_wdata = 32'h5A;
    m_awready = 1'b0; m_wready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("sb.aw_w_valid", 32'({m_awvalid, m_wvalid}), 32'd3);
    chk("sb.awaddr", m_awaddr, 32'h100);
    chk("sb.wdata", m_wdata, 32'h5A5A5A5A);
    chk("sb.wstrb", 32'(m_wstrb), 32'h4);
    tick();
    chk("sb.w_dropped", 32'({m_awvalid, m_wvalid}), 32'd2);
    tick();
    chk("sb.aw_held", 32'({m_awvalid, m_wvalid}), 32'd2);
    chk("sb.awaddr_stable", m_awaddr, 32'h100);
    tick();
    m_awready = 1'b1;
    chk("sb.aw_still", 32'(m_awvalid), 32'd1);
    tick();
    m_awready = 1'b0; m_wready = 1'b0;
    chk("sb.resp_wait", 32'({m_awvalid, m_wvalid, m_bready, store_done}), 32'b0010);
    tick();
    chk("sb.no_done_yet", 32'(store_done), 32'd0);
    m_bvalid = 1'b1; m_bresp = 2'b00;
    #1;
    chk("sb.store_done", 32'(store_done), 32'd1);
    chk("sb.bus_err", 32'(bus_err), 32'd0);
    tick();
    m_bvalid = 1'b0;
    #1;
    chk("sb.ready_after", 32'(req_ready), 32'd1);

    // Other store widths, one with an error response
    run_store("sh002", 32'h002, 3'b001, 32'hABCD1234, 2'b00, 32'h000, 32'h12341234, 4'b1100, 1'b0);
    run_store("sw208", 32'h208, 3'b010, 32'hCAFEBABE, 2'b11, 32'h208, 32'hCAFEBABE, 4'b1111, 1'b1);

    // LH with SLVERR, rvalid delayed, a second request held meanwhile
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b001; req_addr = 32'h102;
    m_arready = 1'b0;
    tick();
    req_funct3 = 3'b010; req_addr = 32'h204;
    chk("lh.busy_ready", 32'(req_ready), 32'd0);
    chk("lh.arvalid", 32'(m_arvalid), 32'd1);
    tick();
    chk("lh.arvalid_held", 32'(m_arvalid), 32'd1);
    chk("lh.araddr_held", m_araddr, 32'h100);
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    chk("lh.rd_data", 32'({m_arvalid, m_rready, req_ready}), 32'b010);
    tick();
    m_rvalid = 1'b1; m_rdata = 32'h80011234; m_rresp = 2'b10;
    #1;
    chk("lh.lsu_rvalid", 32'(lsu_rvalid), 32'd1);
    chk("lh.load_data", load_data, 32'hFFFF8001);
    chk("lh.bus_err", 32'(bus_err), 32'd1);
    chk("lh.ready_in_rd", 32'(req_ready), 32'd0);
    tick();
    m_rvalid = 1'b0; m_rresp = 2'b00;
    #1;
    chk("held.ready_idle", 32'(req_ready), 32'd1);
    chk("held.not_yet", 32'(m_arvalid), 32'd0);
    tick();
    req_valid = 1'b0;
    chk("held.arvalid", 32'(m_arvalid), 32'd1);
    chk("held.araddr", m_araddr, 32'h204);
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h11223344;
    #1;
    chk("held.load_data", load_data, 32'h11223344);
    chk("held.bus_err", 32'(bus_err), 32'd0);
    tick();
    m_rvalid = 1'b0;

    // Reset during RD_DATA with rvalid pending
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
    m_arready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h55555555;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid.valids", 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
                             lsu_rvalid, store_done, bus_err}), 32'd0);
    chk("rstmid.idle", 32'(req_ready), 32'd1);
    m_rvalid = 1'b0;
    tick();

`ifdef LSU_MISALIGN_CHECK_EN
    // Misaligned accesses trap locally
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h101;
    tick();
    req_valid = 1'b0;
    chk("mis_lw.arvalid", 32'(m_arvalid), 32'd0);
    chk("mis_lw.misalign_err", 32'(misalign_err), 32'd1);
    chk("mis_lw.lsu_rvalid", 32'(lsu_rvalid), 32'd1);
    chk("mis_lw.load_data", load_data, 32'd0);
    chk("mis_lw.store_done", 32'(store_done), 32'd0);
    tick();
    chk("mis_lw.after", 32'({misalign_err, lsu_rvalid, m_arvalid}), 32'd0);
    chk("mis_lw.ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h003; req_wdata = 32'h1;
    tick();
    req_valid = 1'b0;
    chk("mis_sh.bus", 32'({m_awvalid, m_wvalid}), 32'd0);
    chk("mis_sh.pulses", 32'({misalign_err, store_done, lsu_rvalid}), 32'b110);
    tick();
    chk("mis_sh.after", 32'({misalign_err, store_done}), 32'd0);
`else
    // Without the check, a misaligned word load goes out word-aligned
    run_load("lw101", 32'h101, 3'b010, 32'hCAFEF00D, 2'b00, 32'h100, 32'hCAFEF00D, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
